// File: rtl/divider_pkg.sv
// Shared FSM encodings for the constant-time divider and its companion testers.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, select.
module divider_restore_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], bit_i};
    // One extra bit so the sign of the trial subtraction is never lost.
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    q_bit_o = ~diff[WIDTH+1];
    rem_o   = q_bit_o ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/divider_const_time.sv
// Constant-time restoring divider: WIDTH steps in RUN, then one DONE cycle, regardless of operands.
module divider_const_time
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             quotientDone,
  output logic             busy,
  output logic             divByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH:0]   rem_d;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_d;

  divider_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign dvd_d = {dvd_q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            dvd_q   <= dividend;
            dsr_q   <= divisor;
            rem_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            quotient_q  <= dvd_d;
            remainder_q <= rem_d[WIDTH-1:0];
            dbz_q       <= (dsr_q == '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign quotientDone = done_q;
  assign busy         = busy_q;
  assign divByZero    = dbz_q;

endmodule

// File: tb/tb_divider_const_time.sv
// Directed bench for divider_const_time at WIDTH=4, with a second instance for lockstep timing.
module tb_divider_const_time;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [W-1:0] dvd_a = '0, dsr_a = '0, dvd_b = '0, dsr_b = '0;
  logic [W-1:0] q_a, r_a, q_b, r_b;
  logic         done_a, busy_a, dbz_a, done_b, busy_b, dbz_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  divider_const_time #(.WIDTH(W)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dividend(dvd_a), .divisor(dsr_a),
    .quotient(q_a), .remainder(r_a), .quotientDone(done_a), .busy(busy_a), .divByZero(dbz_a)
  );

  divider_const_time #(.WIDTH(W)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dividend(dvd_b), .divisor(dsr_b),
    .quotient(q_b), .remainder(r_b), .quotientDone(done_b), .busy(busy_b), .divByZero(dbz_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Start one operation on dut_a and check latency, busy and results edge by edge.
  task automatic run_op(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    @(negedge clk);
    start_a = 1'b1; dvd_a = dvd; dsr_a = dsr;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (done_a !== (k == 5)) begin
        n_bad++;
        $display("FAIL %s done@N+%0d: got %b want %b", name, k, done_a, (k == 5));
      end
      n_cmp++;
      if (busy_a !== (k <= 4)) begin
        n_bad++;
        $display("FAIL %s busy@N+%0d: got %b want %b", name, k, busy_a, (k <= 4));
      end
      if (k == 5) begin
        n_cmp++;
        if (q_a !== eq) begin n_bad++; $display("FAIL %s quotient: got %0d want %0d", name, q_a, eq); end
        n_cmp++;
        if (r_a !== er) begin n_bad++; $display("FAIL %s remainder: got %0d want %0d", name, r_a, er); end
        n_cmp++;
        if (dbz_a !== ez) begin n_bad++; $display("FAIL %s divByZero: got %b want %b", name, dbz_a, ez); end
      end
    end
  endtask

  task automatic test_reset();
    // Start asserted together with reset must not be accepted.
    rst = 1'b1; start_a = 1'b1; dvd_a = 4'd9; dsr_a = 4'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    n_cmp++;
    if ({q_a, r_a, done_a, busy_a, dbz_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got q=%0d r=%0d d=%b b=%b z=%b want all 0", q_a, r_a, done_a, busy_a, dbz_a);
    end
    n_cmp++;
    if ({q_b, r_b, done_b, busy_b, dbz_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got q=%0d r=%0d d=%b b=%b z=%b want all 0", q_b, r_b, done_b, busy_b, dbz_b);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_priority busy: got %b want 0", busy_a); end
  endtask

  task automatic test_basic();
    run_op("13/4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run_op("0/7", 4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_div_by_zero();
    run_op("7/0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
  endtask

  task automatic test_lockstep();
    @(negedge clk);
    start_a = 1'b1; dvd_a = 4'd15; dsr_a = 4'd1;
    start_b = 1'b1; dvd_b = 4'd1;  dsr_b = 4'd15;
    @(posedge clk);
    #1 start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (done_a !== done_b) begin
        n_bad++;
        $display("FAIL timingLeak@N+%0d: done_a=%b done_b=%b", k, done_a, done_b);
      end
      if (k == 5) begin
        n_cmp++;
        if (done_a !== 1'b1) begin n_bad++; $display("FAIL lockstep done: got %b want 1", done_a); end
        n_cmp++;
        if ({q_a, r_a} !== {4'd15, 4'd0}) begin
          n_bad++; $display("FAIL lockstep a result: got %0d r%0d want 15 r0", q_a, r_a);
        end
        n_cmp++;
        if ({q_b, r_b} !== {4'd0, 4'd1}) begin
          n_bad++; $display("FAIL lockstep b result: got %0d r%0d want 0 r1", q_b, r_b);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    @(negedge clk);
    start_a = 1'b1; dvd_a = 4'd13; dsr_a = 4'd4;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      // New operands and start during RUN must have no effect.
      if (k == 1) begin start_a = 1'b1; dvd_a = 4'd15; dsr_a = 4'd1; end
      if (k == 3) start_a = 1'b0;
      if (k == 5) begin
        n_cmp++;
        if (done_a !== 1'b1) begin n_bad++; $display("FAIL restart done: got %b want 1", done_a); end
        n_cmp++;
        if ({q_a, r_a} !== {4'd3, 4'd1}) begin
          n_bad++; $display("FAIL restart result: got %0d r%0d want 3 r1", q_a, r_a);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL restart busy after: got %b want 0", busy_a); end
      end
    end
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    start_a = 1'b1; dvd_a = 4'd14; dsr_a = 4'd3;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({q_a, r_a, done_a, busy_a, dbz_a} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset outputs: got q=%0d r=%0d d=%b b=%b z=%b want all 0",
               q_a, r_a, done_a, busy_a, dbz_a);
    end
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (done_a !== 1'b0) begin n_bad++; $display("FAIL midrun_reset stray done@%0d: got 1 want 0", k); end
    end
    run_op("after_reset 14/3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_a = 1'b1; dvd_a = 4'd9; dsr_a = 4'd2;
    @(posedge clk);
    #1 dvd_a = 4'd10; dsr_a = 4'd3;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (done_a !== (k == 5 || k == 11)) begin
        n_bad++;
        $display("FAIL b2b done@N+%0d: got %b want %b", k, done_a, (k == 5 || k == 11));
      end
      if (k == 5) begin
        n_cmp++;
        if ({q_a, r_a} !== {4'd4, 4'd1}) begin
          n_bad++; $display("FAIL b2b first result: got %0d r%0d want 4 r1", q_a, r_a);
        end
      end
      if (k == 11) begin
        n_cmp++;
        if ({q_a, r_a} !== {4'd3, 4'd1}) begin
          n_bad++; $display("FAIL b2b second result: got %0d r%0d want 3 r1", q_a, r_a);
        end
        start_a = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b idle at end: busy got %b want 0", busy_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_lockstep();
    test_restart_ignored();
    test_midrun_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
